// File: rtl/morse_tx_sequencer_if.sv
// Handshake bundle between the SW/KEY front end and the Morse sequencer.
// The master drives the start pulse and the latched pattern. The slave returns the LED and status.
interface morse_tx_sequencer_if;
    logic       start;
    logic [3:0] letter;
    logic [2:0] length;
    logic       led;
    logic       busy;
    logic       done;

    modport master (
        output start, letter, length,
        input  led, busy, done
    );

    modport slave (
        input  start, letter, length,
        output led, busy, done
    );
endinterface

// File: rtl/morse_tx_sequencer.sv
// Morse transmit sequencer.
// Plays a latched letter pattern (bit 0 first, 1 = dash, 0 = dot) on one LED.
// Every element, including the last one, is followed by an off gap.
// A single-cycle done pulse marks the end of the letter.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; led off, busy low
// S_ON   | LED on for the current element, cyc counting down
// S_GAP  | LED off after an element, cyc counting down
// S_DONE | one-cycle done pulse, then back to S_IDLE
module morse_tx_sequencer #(
    parameter int HALF_SEC_COUNT = 25000000,
    parameter int DOT_UNITS      = 1,
    parameter int DASH_UNITS     = 3,
    parameter int GAP_UNITS      = 1
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    morse_tx_sequencer_if.slave  bus
);

    localparam int DOT_TICKS  = DOT_UNITS  * HALF_SEC_COUNT;
    localparam int DASH_TICKS = DASH_UNITS * HALF_SEC_COUNT;
    localparam int GAP_TICKS  = GAP_UNITS  * HALF_SEC_COUNT;
    localparam int MAX_DG     = (DASH_TICKS > GAP_TICKS) ? DASH_TICKS : GAP_TICKS;
    localparam int CYC_MAX    = (MAX_DG > DOT_TICKS) ? MAX_DG : DOT_TICKS;
    localparam int CYC_W      = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

    // The counter is loaded with duration-1 so that a phase lasts exactly "duration" cycles.
    localparam logic [CYC_W-1:0] DOT_LOAD  = CYC_W'(DOT_TICKS - 1);
    localparam logic [CYC_W-1:0] DASH_LOAD = CYC_W'(DASH_TICKS - 1);
    localparam logic [CYC_W-1:0] GAP_LOAD  = CYC_W'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       sr_q, sr_d;
    logic [2:0]       rem_q, rem_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             led_q, led_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    function automatic logic [CYC_W-1:0] on_load(input logic is_dash);
        return is_dash ? DASH_LOAD : DOT_LOAD;
    endfunction

    // Next-state, datapath and output decode; outputs are decoded from the next state so they leave as flops.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        rem_d   = rem_q;
        cyc_d   = cyc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.length != 3'd0) begin
                        sr_d    = bus.letter;
                        rem_d   = (bus.length > 3'd4) ? 3'd4 : bus.length;
                        cyc_d   = on_load(bus.letter[0]);
                        state_d = S_ON;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ON: begin
                if (cyc_q == '0) begin
                    state_d = S_GAP;
                    cyc_d   = GAP_LOAD;
                    sr_d    = {1'b0, sr_q[3:1]};
                    rem_d   = rem_q - 3'd1;
                end else begin
                    cyc_d = cyc_q - CYC_W'(1);
                end
            end
            S_GAP: begin
                if (cyc_q == '0) begin
                    if (rem_q != 3'd0) begin
                        state_d = S_ON;
                        cyc_d   = on_load(sr_q[0]);
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cyc_d = cyc_q - CYC_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        led_d  = (state_d == S_ON);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers; reset aborts any letter in flight without a done pulse.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            rem_q   <= '0;
            cyc_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            rem_q   <= rem_d;
            cyc_q   <= cyc_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.led  = led_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// Scoreboard bench for morse_tx_sequencer with HALF_SEC_COUNT=4.
// Stimulus pushes the expected LED runs and busy lengths. A negedge monitor closes the runs it sees and compares them.
module tb_morse_tx_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    morse_tx_sequencer_if mif ();

    morse_tx_sequencer #(.HALF_SEC_COUNT(4)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (mif.slave)
    );

    typedef struct {
        int code;   // 0 = led-off run, 1 = led-on run, 2 = done (cnt = busy cycles)
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_on   = 1'b0;
    int   cur_cnt  = 0;
    int   cur_lvl  = 0;
    int   busy_cnt = 0;

    function automatic void check_int(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    task automatic push_item(input int code, input int cnt);
        exp_t e;
        e.code = code;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    function automatic void close_item(input int code, input int cnt);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected output: kind %0d count %0d, expected nothing (t=%0t)", code, cnt, $time);
        end else begin
            e = exp_q.pop_front();
            check_int("item kind", code, e.code);
            check_int(code == 2 ? "busy cycles" : "led run length", cnt, e.cnt);
        end
    endfunction

    // Monitor: tracks LED runs while busy; done closes the letter, idle cycles discard a partial run.
    always @(negedge clk) begin
        if (mon_on) begin
            if (mif.busy === 1'b1) begin
                busy_cnt++;
                if (mif.done === 1'b1) begin
                    if (cur_cnt > 0) close_item(cur_lvl, cur_cnt);
                    close_item(2, busy_cnt);
                    cur_cnt  = 0;
                    busy_cnt = 0;
                end else if (cur_cnt > 0 && int'(mif.led) != cur_lvl) begin
                    close_item(cur_lvl, cur_cnt);
                    cur_lvl = int'(mif.led);
                    cur_cnt = 1;
                end else begin
                    cur_lvl = int'(mif.led);
                    cur_cnt++;
                end
            end else begin
                check_int("done while idle", int'(mif.done), 0);
                check_int("led while idle", int'(mif.led), 0);
                cur_cnt  = 0;
                busy_cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [3:0] l, input logic [2:0] n);
        mif.letter = l;
        mif.length = n;
        mif.start  = 1'b1;
        step();
        mif.start  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (mif.done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done timeout: no done within %0d cycles, expected a pulse", budget);
        end
    endtask

    task automatic push_pair(input int on_cnt);
        push_item(1, on_cnt);
        push_item(0, 4);
    endtask

    initial begin
        reset      = 1'b1;
        mif.start  = 1'b0;
        mif.letter = 4'd0;
        mif.length = 3'd0;
        repeat (3) step();
        check_int("reset led", int'(mif.led), 0);
        check_int("reset busy", int'(mif.busy), 0);
        check_int("reset done", int'(mif.done), 0);
        reset  = 1'b0;
        mon_on = 1'b1;
        step();

        // A: dot, dash
        push_pair(4); push_pair(12); push_item(2, 25);
        pulse_start(4'b0010, 3'd2);
        wait_done(100); step();

        // E: one dot
        push_pair(4); push_item(2, 9);
        pulse_start(4'b0000, 3'd1);
        wait_done(100); step();

        // H: four dots
        push_pair(4); push_pair(4); push_pair(4); push_pair(4); push_item(2, 33);
        pulse_start(4'b0000, 3'd4);
        wait_done(100); step();

        // length 0: straight to done
        push_item(2, 1);
        pulse_start(4'b1111, 3'd0);
        wait_done(20); step();

        // G: dash dash dot, with start pulses and SW changes mid-letter
        push_pair(12); push_pair(12); push_pair(4); push_item(2, 41);
        pulse_start(4'b0011, 3'd3);
        repeat (5) step();
        for (int i = 0; i < 4; i++) begin
            mif.letter = 4'hC - 4'(i);
            mif.length = 3'(i);
            mif.start  = 1'b1;
            step();
            mif.start  = 1'b0;
            repeat (6) step();
        end
        wait_done(100); step();

        // B aborted by reset in the middle of its dash: nothing is pushed, so any run or done would be flagged
        pulse_start(4'b0001, 3'd4);
        repeat (7) step();
        reset = 1'b1;
        step();
        check_int("abort led", int'(mif.led), 0);
        check_int("abort busy", int'(mif.busy), 0);
        check_int("abort done", int'(mif.done), 0);
        reset = 1'b0;
        repeat (30) step();

        // normal letter after the abort
        push_pair(4); push_item(2, 9);
        pulse_start(4'b0000, 3'd1);
        wait_done(100); step();

        // length 7 clamps to 4 elements; start held across DONE is taken only once back in IDLE
        push_pair(12); push_pair(4); push_pair(12); push_pair(4); push_item(2, 49);
        push_pair(12); push_pair(4); push_pair(12); push_pair(4); push_item(2, 49);
        mif.letter = 4'b0101;
        mif.length = 3'd7;
        mif.start  = 1'b1;
        wait_done(200);
        step();
        check_int("start ignored in DONE", int'(mif.busy), 0);
        step();
        check_int("start accepted in IDLE", int'(mif.busy), 1);
        mif.start  = 1'b0;
        mif.letter = 4'b0000;
        mif.length = 3'd1;
        wait_done(200); step();

        repeat (5) step();
        check_int("leftover expectations", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
